// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with line buffers and frame tracking
module sobel_stream #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              mode,
    input  logic [DATA_W-1:0] threshold,
    output logic              valid_out,
    output logic [DATA_W-1:0] pixel_out,
    output logic              eof_out
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int GW = DATA_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [GW-1:0] PIX_MAX  = {4'b0000, {DATA_W{1'b1}}};

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q, lb2_q;
    logic [DATA_W-1:0] win [3][3];
    logic              s1_valid, s1_eof;

    assign lb1_q = lb1[col];
    assign lb2_q = lb2[col];

    // Line buffers carry no reset; rows 0-1 never emit so stale data is never seen.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb2[col] <= lb1_q;
            lb1[col] <= pixel_in;
        end
    end

    // S1: window shift and raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            s1_valid <= 1'b0;
            s1_eof   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            s1_valid <= valid_in && (row >= RW'(2)) && (col >= CW'(2));
            s1_eof   <= valid_in && (row == ROW_LAST) && (col == COL_LAST);
            if (valid_in) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_q;
                win[1][2] <= lb1_q;
                win[2][2] <= pixel_in;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    function automatic logic signed [GW-1:0] sx(input logic [DATA_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    logic signed [GW-1:0] gx_c, gy_c, gx, gy;
    logic                 s2_valid, s2_eof;

    always_comb begin
        gx_c = (sx(win[0][2]) + (sx(win[1][2]) <<< 1) + sx(win[2][2]))
             - (sx(win[0][0]) + (sx(win[1][0]) <<< 1) + sx(win[2][0]));
        gy_c = (sx(win[2][0]) + (sx(win[2][1]) <<< 1) + sx(win[2][2]))
             - (sx(win[0][0]) + (sx(win[0][1]) <<< 1) + sx(win[0][2]));
    end

    // S2: gradients
    always_ff @(posedge clk) begin
        if (rst) begin
            gx       <= '0;
            gy       <= '0;
            s2_valid <= 1'b0;
            s2_eof   <= 1'b0;
        end else begin
            gx       <= gx_c;
            gy       <= gy_c;
            s2_valid <= s1_valid;
            s2_eof   <= s1_eof;
        end
    end

    logic [GW-1:0]     abs_x, abs_y, mag;
    logic [DATA_W-1:0] mag_sat;
    logic              thr_hit;

    always_comb begin
        abs_x   = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_y   = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag     = abs_x + abs_y;
        mag_sat = (mag > PIX_MAX) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
        thr_hit = (mag >= {4'b0000, threshold});
    end

    // S3: magnitude select and output registers; pixel_out holds across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            pixel_out <= '0;
            eof_out   <= 1'b0;
        end else begin
            valid_out <= s2_valid;
            eof_out   <= s2_valid && s2_eof;
            if (s2_valid) begin
                if (mode) begin
                    pixel_out <= thr_hit ? {DATA_W{1'b1}} : '0;
                end else begin
                    pixel_out <= mag_sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - directed self-checking bench for sobel_stream
module tb_sobel_stream;
    localparam int W = 8;
    localparam int H = 6;
    localparam int NR = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic       mode = 1'b0;
    logic [7:0] threshold = 8'd0;
    logic       valid_out;
    logic [7:0] pixel_out;
    logic       eof_out;

    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pixel_in(pixel_in),
        .mode(mode), .threshold(threshold),
        .valid_out(valid_out), .pixel_out(pixel_out), .eof_out(eof_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int q_pix[$];
    int q_eof[$];
    int q_cyc[$];
    int e_cyc[$];
    int n_cmp = 0;
    int n_err = 0;
    int rst_cyc = 0;

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            q_pix.push_back(int'(pixel_out));
            q_eof.push_back(int'(eof_out));
            q_cyc.push_back(cyc);
        end
    end

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 100;
            1:       return 4 * c;
            2:       return (c >= 4) ? 255 : 0;
            default: return (r >= 3) ? 255 : 0;
        endcase
    endfunction

    // Unsaturated |Gx|+|Gy| of result k, worked out by hand for each pattern.
    function automatic int exp_mag(input int pat, input int k);
        int rr, cc;
        rr = k / (W - 2) + 1;
        cc = k % (W - 2) + 1;
        case (pat)
            0:       return 0;
            1:       return 32;
            2:       return (cc == 3 || cc == 4) ? 1020 : 0;
            default: return (rr == 2 || rr == 3) ? 1020 : 0;
        endcase
    endfunction

    function automatic int exp_val(input int pat, input int m, input int thr, input int k);
        int mg;
        mg = exp_mag(pat, k);
        if (m != 0) return (mg >= thr) ? 255 : 0;
        return (mg > 255) ? 255 : mg;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            rst = 1'b0;
        end
    endtask

    task automatic clear_q();
        q_pix.delete();
        q_eof.delete();
        q_cyc.delete();
        e_cyc.delete();
    endtask

    task automatic drive_frame(input int pat, input bit gaps, input int ab_r, input int ab_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) begin
                    for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) idle(1);
                end
                @(posedge clk);
                #1;
                valid_in = 1'b1;
                pixel_in = 8'(pix(pat, r, c));
                if (r == ab_r && c == ab_c) begin
                    rst = 1'b1;
                    rst_cyc = cyc;
                    return;
                end
                if (r >= 2 && c >= 2) e_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic check_run(input string name, input int pat0, input int pat1,
                             input int nf, input int m, input int thr);
        int n, pat;
        chk($sformatf("%s count", name), q_pix.size(), NR * nf);
        n = q_pix.size();
        if (e_cyc.size() < n) n = e_cyc.size();
        if (NR * nf < n) n = NR * nf;
        for (int k = 0; k < n; k++) begin
            pat = (k < NR) ? pat0 : pat1;
            chk($sformatf("%s pix[%0d]", name, k), q_pix[k], exp_val(pat, m, thr, k % NR));
            chk($sformatf("%s eof[%0d]", name, k), q_eof[k], (k % NR == NR - 1) ? 1 : 0);
            chk($sformatf("%s lat[%0d]", name, k), q_cyc[k] - e_cyc[k], 3);
        end
    endtask

    initial begin
        int late;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid_out", int'(valid_out), 0);
        chk("reset pixel_out", int'(pixel_out), 0);
        chk("reset eof_out", int'(eof_out), 0);
        idle(2);

        clear_q();
        mode = 1'b0;
        drive_frame(0, 1'b0, -1, -1);
        idle(6);
        check_run("const", 0, 0, 1, 0, 0);

        clear_q();
        drive_frame(1, 1'b0, -1, -1);
        idle(6);
        check_run("ramp_mag", 1, 1, 1, 0, 0);

        clear_q();
        mode = 1'b1;
        threshold = 8'd32;
        drive_frame(1, 1'b0, -1, -1);
        idle(6);
        check_run("ramp_th32", 1, 1, 1, 1, 32);

        clear_q();
        threshold = 8'd33;
        drive_frame(1, 1'b0, -1, -1);
        idle(6);
        check_run("ramp_th33", 1, 1, 1, 1, 33);

        clear_q();
        mode = 1'b0;
        drive_frame(2, 1'b0, -1, -1);
        idle(6);
        check_run("vedge", 2, 2, 1, 0, 0);

        clear_q();
        drive_frame(2, 1'b1, -1, -1);
        idle(6);
        check_run("vedge_gaps", 2, 2, 1, 0, 0);

        clear_q();
        drive_frame(1, 1'b0, 3, 4);
        idle(8);
        late = 0;
        foreach (q_cyc[i]) if (q_cyc[i] > rst_cyc) late++;
        chk("valid after rst", late, 0);
        clear_q();
        drive_frame(0, 1'b0, -1, -1);
        idle(6);
        check_run("post_rst", 0, 0, 1, 0, 0);

        clear_q();
        drive_frame(2, 1'b0, -1, -1);
        drive_frame(3, 1'b0, -1, -1);
        idle(6);
        check_run("b2b", 2, 3, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
